// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, one-hot output-port codes and the
// input-port FSM state encoding.
package noc_pkg;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  // One-hot output port order: [0]=L [1]=E [2]=W [3]=N [4]=S
  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_E = 5'b00010;
  localparam logic [4:0] P_W = 5'b00100;
  localparam logic [4:0] P_N = 5'b01000;
  localparam logic [4:0] P_S = 5'b10000;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/route_compute.sv
// Dimension-order route selection: XY or YX, unsigned coordinate compares.
// Purely combinational; output is a one-hot port code.
module route_compute
  import noc_pkg::*;
#(
  parameter int X_W      = 2,
  parameter int Y_W      = 2,
  parameter int ROUTE_YX = 0
) (
  input  logic [X_W-1:0] x_cur,
  input  logic [Y_W-1:0] y_cur,
  input  logic [X_W-1:0] x_dst,
  input  logic [Y_W-1:0] y_dst,
  output logic [4:0]     port
);

  if (ROUTE_YX != 0) begin : g_yx
    always_comb begin
      port = P_L;
      if (y_dst > y_cur)      port = P_N;
      else if (y_dst < y_cur) port = P_S;
      else if (x_dst > x_cur) port = P_E;
      else if (x_dst < x_cur) port = P_W;
    end
  end else begin : g_xy
    always_comb begin
      port = P_L;
      if (x_dst > x_cur)      port = P_E;
      else if (x_dst < x_cur) port = P_W;
      else if (y_dst > y_cur) port = P_N;
      else if (y_dst < y_cur) port = P_S;
    end
  end

endmodule

// File: rtl/input_port_router.sv
// Per-input-port wormhole controller: routes the head flit, holds the output
// request for the packet, drops orphan flits and flags a missing tail.
module input_port_router
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int ROUTE_YX   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_W-1:0]        x_cur,
  input  logic [Y_W-1:0]        y_cur,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic [4:0]            out_req,
  input  logic                  out_grant,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  output logic                  route_err,
  output logic [CNT_W-1:0]      pkt_cnt
);

  state_e           state_q, state_d;
  logic [4:0]       route_q, route_d, route_calc;
  logic             first_q, first_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ftype;
  logic             head_like;

  assign ftype     = fifo_data[DATA_WIDTH-1 -: 2];
  assign head_like = (ftype == FT_HEAD) || (ftype == FT_SINGLE);

  route_compute #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .ROUTE_YX (ROUTE_YX)
  ) u_route (
    .x_cur (x_cur),
    .y_cur (y_cur),
    .x_dst (fifo_data[X_W-1:0]),
    .y_dst (fifo_data[X_W+Y_W-1:X_W]),
    .port  (route_calc)
  );

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    first_d    = first_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    fifo_read  = 1'b0;
    flit_valid = 1'b0;
    flit_out   = '0;
    out_req    = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_like) begin
            route_d = route_calc;
            first_d = 1'b1;
            state_d = S_ACTIVE;
          end else begin
            fifo_read = 1'b1;
            err_d     = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        out_req = route_q;
        // A HEAD after the packet's own first flit means the tail went missing;
        // leave it in the FIFO so IDLE routes it as a fresh packet.
        if (!fifo_empty && (ftype == FT_HEAD) && !first_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (out_grant && !fifo_empty) begin
          fifo_read  = 1'b1;
          flit_valid = 1'b1;
          flit_out   = fifo_data;
          first_d    = 1'b0;
          if ((ftype == FT_TAIL) || (ftype == FT_SINGLE)) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      fifo_read  = 1'b0;
      flit_valid = 1'b0;
      flit_out   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      route_q <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      first_q <= first_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign route_err = err_q;
  assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_input_port_router.sv
// Directed bench for input_port_router: XY and YX instances share one FIFO model
// driven by the XY instance's pops; router sits at (1,1).
module tb_input_port_router;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  x_cur = 2'd1;
  logic [1:0]  y_cur = 2'd1;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        out_grant;
  logic        fifo_read, flit_valid, route_err;
  logic [4:0]  out_req;
  logic [15:0] flit_out;
  logic [15:0] pkt_cnt;
  logic        yx_fifo_read, yx_flit_valid, yx_route_err;
  logic [4:0]  yx_out_req;
  logic [15:0] yx_flit_out;
  logic [15:0] yx_pkt_cnt;

  logic [15:0] fq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  input_port_router dut (
    .clk(clk), .rst(rst), .x_cur(x_cur), .y_cur(y_cur),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .out_req(out_req), .out_grant(out_grant), .flit_out(flit_out),
    .flit_valid(flit_valid), .route_err(route_err), .pkt_cnt(pkt_cnt)
  );

  input_port_router #(.ROUTE_YX(1)) dut_yx (
    .clk(clk), .rst(rst), .x_cur(x_cur), .y_cur(y_cur),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(yx_fifo_read),
    .out_req(yx_out_req), .out_grant(out_grant), .flit_out(yx_flit_out),
    .flit_valid(yx_flit_valid), .route_err(yx_route_err), .pkt_cnt(yx_pkt_cnt)
  );

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                     input logic [1:0] dy, input logic [9:0] tag);
    return {t, tag, dy, dx};
  endfunction

  task automatic upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 16'h0 : fq[0];
  endtask

  task automatic push(input logic [15:0] f);
    fq.push_back(f);
    upd();
  endtask

  // Sample the pop decision before the edge, apply it after, return at negedge.
  task automatic cyc();
    logic p;
    #1;
    p = fifo_read;
    @(posedge clk);
    if (p && fq.size() > 0) void'(fq.pop_front());
    #1;
    upd();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] dx;
    logic [1:0] dy;
    logic [4:0] exp_xy;
    logic [4:0] exp_yx;
  } rvec_t;

  rvec_t       tbl[8];
  logic [15:0] f;
  logic [15:0] pk[4];

  initial begin
    tbl[0] = '{2'd1, 2'd1, P_L, P_L};
    tbl[1] = '{2'd3, 2'd0, P_E, P_S};
    tbl[2] = '{2'd0, 2'd1, P_W, P_W};
    tbl[3] = '{2'd1, 2'd3, P_N, P_N};
    tbl[4] = '{2'd0, 2'd3, P_W, P_N};
    tbl[5] = '{2'd2, 2'd2, P_E, P_N};
    tbl[6] = '{2'd1, 2'd0, P_S, P_S};
    tbl[7] = '{2'd0, 2'd0, P_W, P_S};

    rst = 1'b1;
    out_grant = 1'b1;
    upd();
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("reset out_req", 32'(out_req), 32'h0);
    chk("reset pkt_cnt", 32'(pkt_cnt), 32'h0);
    chk("reset route_err", 32'(route_err), 32'h0);
    chk("reset fifo_read", 32'(fifo_read), 32'h0);
    chk("reset flit_valid", 32'(flit_valid), 32'h0);

    // SINGLE flits through the route table (entry 0 is the local case)
    for (int i = 0; i < 8; i++) begin
      f = mk(FT_SINGLE, tbl[i].dx, tbl[i].dy, 10'(i));
      push(f);
      #1;
      chk("idle out_req", 32'(out_req), 32'h0);
      chk("idle no pop", 32'(fifo_read), 32'h0);
      cyc();
      chk($sformatf("route xy %0d", i), 32'(out_req), 32'(tbl[i].exp_xy));
      chk($sformatf("route yx %0d", i), 32'(yx_out_req), 32'(tbl[i].exp_yx));
      chk("single pop", 32'(fifo_read), 32'h1);
      chk("single flit_out", 32'(flit_out), 32'(f));
      cyc();
      exp_cnt++;
      chk("single released", 32'(out_req), 32'h0);
      chk("single pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
      chk("single pkt_cnt yx", 32'(yx_pkt_cnt), 32'(exp_cnt));
    end

    // 4-flit packet, grant held high
    pk[0] = mk(FT_HEAD, 2'd3, 2'd0, 10'h11);
    pk[1] = mk(FT_BODY, 2'd0, 2'd0, 10'h12);
    pk[2] = mk(FT_BODY, 2'd0, 2'd0, 10'h13);
    pk[3] = mk(FT_TAIL, 2'd0, 2'd0, 10'h14);
    for (int i = 0; i < 4; i++) push(pk[i]);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("pkt out_req E", 32'(out_req), 32'(P_E));
      chk("pkt out_req S yx", 32'(yx_out_req), 32'(P_S));
      chk("pkt flit_valid", 32'(flit_valid), 32'h1);
      chk("pkt flit_out", 32'(flit_out), 32'(pk[i]));
      cyc();
    end
    exp_cnt++;
    chk("pkt released", 32'(out_req), 32'h0);
    chk("pkt pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // same packet, grant low for 3 cycles
    out_grant = 1'b0;
    for (int i = 0; i < 4; i++) push(pk[i]);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("stall out_req held", 32'(out_req), 32'(P_E));
      chk("stall no pop", 32'(fifo_read), 32'h0);
      chk("stall flit_out zero", 32'(flit_out), 32'h0);
      cyc();
    end
    out_grant = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("resume out_req", 32'(out_req), 32'(P_E));
      chk("resume pop", 32'(fifo_read), 32'h1);
      chk("resume flit_out", 32'(flit_out), 32'(pk[i]));
      cyc();
    end
    exp_cnt++;
    chk("resume pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // orphan BODY in IDLE
    push(mk(FT_BODY, 2'd2, 2'd2, 10'h21));
    #1;
    chk("orphan pop", 32'(fifo_read), 32'h1);
    chk("orphan flit_valid", 32'(flit_valid), 32'h0);
    chk("orphan err early", 32'(route_err), 32'h0);
    cyc();
    chk("orphan route_err", 32'(route_err), 32'h1);
    chk("orphan drained", 32'(fq.size()), 32'h0);
    chk("orphan pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    cyc();
    chk("orphan err once", 32'(route_err), 32'h0);

    // HEAD with no tail followed by another HEAD
    f = mk(FT_HEAD, 2'd1, 2'd3, 10'h32);
    push(mk(FT_HEAD, 2'd0, 2'd1, 10'h31));
    push(f);
    cyc();
    chk("stray first route W", 32'(out_req), 32'(P_W));
    chk("stray first pop", 32'(fifo_read), 32'h1);
    cyc();
    chk("stray head no pop", 32'(fifo_read), 32'h0);
    chk("stray head route held", 32'(out_req), 32'(P_W));
    cyc();
    chk("stray route_err", 32'(route_err), 32'h1);
    chk("stray route dropped", 32'(out_req), 32'h0);
    chk("stray head kept", 32'(fq.size()), 32'h1);
    chk("stray pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
    cyc();
    chk("reroute N", 32'(out_req), 32'(P_N));
    chk("reroute pop head", 32'(flit_out), 32'(f));
    cyc();
    push(mk(FT_TAIL, 2'd0, 2'd0, 10'h33));
    cyc();
    exp_cnt++;
    chk("reroute done", 32'(out_req), 32'h0);
    chk("reroute pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));

    // reset in the middle of a packet
    for (int i = 0; i < 4; i++) push(pk[i]);
    cyc();
    cyc();
    cyc();
    chk("mid two popped", 32'(fq.size()), 32'h2);
    rst = 1'b1;
    #1;
    chk("rst blocks pop", 32'(fifo_read), 32'h0);
    cyc();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rst out_req", 32'(out_req), 32'h0);
    chk("rst pkt_cnt", 32'(pkt_cnt), 32'h0);
    #1;
    chk("rst orphan body pop", 32'(fifo_read), 32'h1);
    chk("rst orphan no valid", 32'(flit_valid), 32'h0);
    cyc();
    chk("rst body err", 32'(route_err), 32'h1);
    chk("rst orphan tail pop", 32'(fifo_read), 32'h1);
    cyc();
    chk("rst tail err", 32'(route_err), 32'h1);
    chk("rst fifo drained", 32'(fq.size()), 32'h0);
    cyc();
    chk("rst err clear", 32'(route_err), 32'h0);
    chk("rst pkt_cnt final", 32'(pkt_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
